// File: rtl/rca_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rca / rca_pipe                                                  |
// | Purpose  : rca      - combinational CHUNK-bit ripple-carry adder slice.    |
// |            rca_pipe - WIDTH-bit add/subtract split into WIDTH/CHUNK        |
// |                       registered ripple stages with a valid/ready          |
// |                       handshake and one global advance signal.             |
// | Options  : RCA_PIPE_OVF_EN - adds the registered signed-overflow port Ovf. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module rca #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o
);

   // One slice of the chain: {carry, sum} = a + b + carry-in over WIDTH+1 bits.
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};

endmodule

module rca_pipe #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef RCA_PIPE_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int c_STAGES = WIDTH / CHUNK;

   // Stage k keeps {B remaining, A remaining, finished sum bits} in one slice
   // of a flat register. The slice shrinks by CHUNK bits per stage because each
   // stage consumes CHUNK bits from each operand and adds CHUNK sum bits.
   // f_doff returns the bit offset of stage k's slice in that flat register.
   function automatic int f_doff(input int k);
      return (2 * WIDTH * k) - (CHUNK * k * (k + 1)) / 2;
   endfunction

   localparam int c_DATA_W = f_doff(c_STAGES);

   logic                w_adv;
   logic [WIDTH-1:0]    w_bx;
   logic                w_c0;
   logic [c_DATA_W-1:0] w_data_d;
   logic [c_DATA_W-1:0] r_data_q;
   logic [c_STAGES-1:0] w_c_d;
   logic [c_STAGES-1:0] r_c_q;
   logic [c_STAGES-1:0] w_v_d;
   logic [c_STAGES-1:0] r_v_q;
`ifdef RCA_PIPE_OVF_EN
   logic                w_ovf_d;
   logic                r_ovf_q;
`endif

   // Whole pipe moves together; it only freezes when a result is waiting.
   assign w_adv    = out_ready | ~r_v_q[c_STAGES-1];
   assign in_ready = w_adv;

   // Subtraction is A + ~B + 1, so Cin is ignored for Sub.
   assign w_bx = Sub ? ~B : B;
   assign w_c0 = Sub | Cin;

   for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
      localparam int c_PS  = k * CHUNK;          // sum bits already finished
      localparam int c_PR  = WIDTH - c_PS;       // operand bits still pending
      localparam int c_RW  = c_PR - CHUNK;       // operand bits left after this stage
      localparam int c_SRC = c_PS + 2 * c_PR;    // width of this stage's source slice

      logic [c_SRC-1:0] w_src;
      logic             w_cin;
      logic [CHUNK-1:0] w_s;

      if (k == 0) begin : g_first
         assign w_src    = {w_bx, A};
         assign w_cin    = w_c0;
         assign w_v_d[k] = in_valid;
      end else begin : g_next
         assign w_src    = r_data_q[f_doff(k - 1) +: c_SRC];
         assign w_cin    = r_c_q[k - 1];
         assign w_v_d[k] = r_v_q[k - 1];
      end

      rca #(
         .WIDTH (CHUNK)
      ) u_rca (
         .a_i   (w_src[c_PS +: CHUNK]),
         .b_i   (w_src[c_PS + c_PR +: CHUNK]),
         .c_i   (w_cin),
         .s_o   (w_s),
         .c_o   (w_c_d[k])
      );

      // Drop the consumed operand chunks, append this stage's sum chunk.
      if (c_RW > 0) begin : g_skew
         if (k > 0) begin : g_mid
            assign w_data_d[f_doff(k) +: (c_SRC - CHUNK)] =
               {w_src[c_PS + c_PR + CHUNK +: c_RW], w_src[c_PS + CHUNK +: c_RW],
                w_s, w_src[c_PS-1:0]};
         end else begin : g_head
            assign w_data_d[f_doff(k) +: (c_SRC - CHUNK)] =
               {w_src[c_PS + c_PR + CHUNK +: c_RW], w_src[c_PS + CHUNK +: c_RW], w_s};
         end
      end else begin : g_tail
         if (k > 0) begin : g_multi
            assign w_data_d[f_doff(k) +: (c_SRC - CHUNK)] = {w_s, w_src[c_PS-1:0]};
         end else begin : g_single
            assign w_data_d[f_doff(k) +: (c_SRC - CHUNK)] = w_s;
         end
      end

`ifdef RCA_PIPE_OVF_EN
      if (k == c_STAGES - 1) begin : g_ovf
         // Carry into the MSB is a^b^s at the top bit; overflow is that XOR carry-out.
         assign w_ovf_d = w_src[c_PS + CHUNK - 1] ^ w_src[c_PS + c_PR + CHUNK - 1]
                        ^ w_s[CHUNK-1] ^ w_c_d[k];
      end
`endif
   end

   // Stage registers: clear on reset, load from predecessor on advance, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v_q    <= '0;
         r_c_q    <= '0;
         r_data_q <= '0;
      end else if (w_adv) begin
         r_v_q    <= w_v_d;
         r_c_q    <= w_c_d;
         r_data_q <= w_data_d;
      end
   end

`ifdef RCA_PIPE_OVF_EN
   // Overflow flag rides alongside the last-stage sum and stalls with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_q <= 1'b0;
      end else if (w_adv) begin
         r_ovf_q <= w_ovf_d;
      end
   end

   assign Ovf = r_ovf_q;
`endif

   assign out_valid = r_v_q[c_STAGES-1];
   assign Cout      = r_c_q[c_STAGES-1];
   assign Sum       = r_data_q[f_doff(c_STAGES - 1) +: WIDTH];

endmodule

`default_nettype wire

// File: doc/rca_pipe.md
# rca_pipe

- Pipelined, parametrised successor to the combinational `rca` adder.
- Splits a WIDTH-bit add/subtract into WIDTH/CHUNK ripple-carry stages, each built from one `rca #(CHUNK)` instance. A registered carry passes between stages.
- Accepts one operation per cycle under a valid/ready handshake and stalls cleanly under output backpressure.
- Used wherever wide adds (32/64-bit) must close timing at the datapath clock.

## Interface

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of CHUNK.
- CHUNK, 16, bits per stage; STAGES = WIDTH/CHUNK, 1 ≤ STAGES ≤ 16.

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in; ignored when Sub=1
- Sub  input  1  1: compute A + ~B + 1
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out of the MSB (for Sub, 1 = no borrow)
- Ovf  output  1  signed overflow (only with RCA_PIPE_OVF_EN)

## Operation

- **Operand conditioning at input:**
  - Bx = Sub ? ~B : B.
  - c0 = Sub ? 1 : Cin.
- **Stage k (0..STAGES-1):**
  - Computes {c_k+1, S[k]} = A[k] + Bx[k] + c_k over CHUNK+1 bits, where [k] is bits k*CHUNK+CHUNK-1 : k*CHUNK.
  - Registers the sum slice, the carry, and a valid bit.
- **Skew:** operand slices for later stages travel forward in stage registers until consumed.
- **Deskew:** completed sum slices travel forward until the last stage, so Sum is word-aligned at the output.
- **Single global advance:** adv = out_ready | ~out_valid.
  - in_ready = adv.
  - When adv=1, every stage register loads from its predecessor; stage 0 loads the input with valid = in_valid.
  - When adv=0, every register holds, including the valid bits.
- **Bubbles:** propagate as valid=0 slots; they are not collapsed.
- **Arithmetic:** results match {Cout,Sum} = A + Bx + c0, computed at WIDTH+1 bits (mod 2^(WIDTH+1)).
- **STAGES=1:** behaves as a single registered `rca` with handshake.
- **No internal state machine:** control is the per-stage valid bits plus adv.

## Timing

- **Reset (rst=1 at a rising edge):**
  - All stage valid bits, data and carry registers clear.
  - Next cycle: out_valid=0, Sum=0, Cout=0, Ovf=0.
  - in_ready=1, since it follows adv.
- **Latency:** an operation accepted at edge N (in_valid & in_ready) presents out_valid=1 after edge N+STAGES-1. Example: WIDTH=64, CHUNK=16 gives 4 registered stages, so the result is visible in the cycle after the 4th edge inclusive of acceptance.
- **Throughput:** 1 op/cycle while out_ready=1.
- **Output hold:** while out_valid=1 and out_ready=0:
  - Sum/Cout/Ovf hold stable.
  - in_ready=0.
  - In-flight operations do not advance or get lost.
- **Input rule:** the input is not registered when in_valid=1 and in_ready=0; the producer must hold its operands.
- **Simultaneous accept and retire:** both occur in one cycle when adv=1.
- **Reset mid-operation:** all in-flight operations are discarded with no output; rst overrides in_valid on the same edge.
- **Outputs:** come directly from the last-stage registers, with no combinational path from A/B.

## Configuration

- **RCA_PIPE_OVF_EN defined:**
  - Port Ovf exists.
  - The last stage registers Ovf = c_in(MSB) XOR Cout, i.e. signed overflow of A ± B.
  - Ovf resets to 0 and is pipelined and stalled identically to Sum.
- **RCA_PIPE_OVF_EN undefined:**
  - No Ovf port and no associated logic.
  - All other behaviour is identical.

## Test plan

- **Reset then idle:** rst=1 for 2 cycles → out_valid=0, Sum=0, Cout=0, in_ready=1.
- **Basic add (WIDTH=64, CHUNK=16):**
  - Stimulus: A=64'hFFFFFFFFFFFFFFFF, B=0, Cin=1, Sub=0, out_ready=1.
  - Response: exactly 4 edges later, Sum=0 and Cout=1, which exercises the full cross-stage carry chain.
- **Subtract:**
  - Stimulus: A=64'h65, B=64'h66, Sub=1, Cin=1 (Cin must be ignored).
  - Response: Sum=64'hFFFFFFFFFFFFFFFF, Cout=0.
  - With RCA_PIPE_OVF_EN, Ovf=0.
- **Streaming and backpressure:**
  - Stimulus: 8 back-to-back ops (A=i, B=i<<1), with out_ready=0 for 3 cycles mid-stream.
  - Response: all 8 results (3i) emerge in order with none dropped or duplicated; in_ready=0 during the stall; output holds stable.
- **Overflow (RCA_PIPE_OVF_EN, WIDTH=8, CHUNK=8):**
  - A=8'h7F, B=8'h01, Sub=0 → after 1 edge, Sum=8'h80, Ovf=1, Cout=0.
  - A=8'hAA, B=8'h55 → Sum=8'hFF, Ovf=0.
- **Reset mid-flight:**
  - Stimulus: issue 3 ops, assert rst for 1 cycle before any result.
  - Response: no out_valid pulse follows; the next op issued after reset returns a correct result at nominal latency.
